// File: rtl/counter_top_pkg.sv
// counter_top_pkg: shared constants for the register-mapped event counter.
// Register addresses are byte addresses on the local register bus.
// Bit indices locate fields within the CR and SR words.
package counter_top_pkg;

  // Default counter width; the OVF flag sits just above the count in SR.
  localparam int CNT_W_DEFAULT = 3;

  // Register map.
  localparam int unsigned CR_ADDR = 32'h000;
  localparam int unsigned SR_ADDR = 32'h004;

  // Field positions.
  localparam int CR_PULSE_BIT = 0;
  localparam int CR_CLR_BIT   = 1;
  localparam int SR_OVF_BIT   = 3;

endpackage

// File: rtl/counter_core.sv
// counter_core: CNT_W-bit modulo counter with increment and clear inputs.
// Latency: count updates on the edge after inc_i; wrap_o is combinational and
// is high for exactly the cycle in which an increment takes all-ones to zero.
module counter_core
  import counter_top_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear dominates increment, increment wraps modulo 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i & ~clr_i & (&cnt_q);

endmodule

// File: rtl/counter_top_regs.sv
// counter_top_regs: register-bus front end for the event counter (CR at 0x000,
// SR at 0x004). Single-cycle bus, no wait states; rdata is registered and held.
// Optional feature macro: COUNTER_TOP_STICKY_OVF_EN enables the sticky OVF flag.
module counter_top_regs
  import counter_top_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              overflow
);

  logic              cr_sel;
  logic              sr_sel;
  logic              cr_wr;
  logic              sr_wr;
  logic              clr_q;
  logic              clr_d;
  logic              pulse_q;
  logic              pulse_d;
  logic              ovf;
  logic              wrap;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  assign cr_sel = (addr == ADDR_W'(CR_ADDR));
  assign sr_sel = (addr == ADDR_W'(SR_ADDR));
  assign cr_wr  = wr_en & cr_sel;
  assign sr_wr  = wr_en & sr_sel;

  // CR next state: CLR is a plain level; a pulse is only accepted when neither
  // the same write nor the current CLR level is clearing the counter.
  always_comb begin
    clr_d   = clr_q;
    pulse_d = 1'b0;
    if (cr_wr) begin
      clr_d   = wdata[CR_CLR_BIT];
      pulse_d = wdata[CR_PULSE_BIT] & ~wdata[CR_CLR_BIT] & ~clr_q;
    end
  end

  // Read mux samples pre-write state, so a simultaneous write is not visible.
  always_comb begin
    rd_val = '0;
    if (cr_sel) begin
      rd_val[CR_CLR_BIT] = clr_q;
    end else if (sr_sel) begin
      rd_val[CNT_W-1:0] = cnt;
      rd_val[CNT_W]     = ovf;
    end
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // Control and read-data registers; reset overrides any bus access.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q   <= 1'b0;
      pulse_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      clr_q   <= clr_d;
      pulse_q <= pulse_d;
      rdata_q <= rdata_d;
    end
  end

  counter_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (pulse_q),
    .clr_i  (clr_q),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

`ifdef COUNTER_TOP_STICKY_OVF_EN
  logic ovf_q;
  logic ovf_d;
  logic unused_wdata;

  // Sticky OVF: write-0 clears, a wrap in the same cycle takes priority.
  always_comb begin
    ovf_d = ovf_q;
    if (sr_wr && !wdata[CNT_W]) begin
      ovf_d = 1'b0;
    end
    if (wrap) begin
      ovf_d = 1'b1;
    end
  end

  // OVF flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf          = ovf_q;
  assign unused_wdata = ^wdata;
`else
  logic unused_bits;

  // Without the sticky flag the counter still wraps, but nothing records it.
  assign ovf         = 1'b0;
  assign unused_bits = ^{wdata, wrap, sr_wr};
`endif

  assign rdata    = rdata_q;
  assign overflow = ovf;

endmodule

// File: tb/tb_counter_top_regs.sv
// tb_counter_top_regs: scoreboard bench for the register-mapped counter.
// Reads push their expected word when issued and are compared after the edge.
// Expected OVF-related values follow COUNTER_TOP_STICKY_OVF_EN.
module tb_counter_top_regs;

  localparam int CNT_W  = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

`ifdef COUNTER_TOP_STICKY_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [31:0] OVF_WORD = OVF_EN ? 32'h8 : 32'h0;

  localparam logic [9:0] CR  = 10'h000;
  localparam logic [9:0] SR  = 10'h004;
  localparam logic [9:0] BAD = 10'h008;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  counter_top_regs #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic bus(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d);
    logic [31:0] e;
    string       t;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (r) begin
      chk_eq("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk_eq(t, rdata, e);
      end
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    bus(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic pulses(input int n);
    repeat (n) wr(CR, 32'h1);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_rdata", rdata, 32'h0);
    chk_eq("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(SR, 32'h0, "rst_sr");

    // Basic counting
    pulses(3);
    idle(1);
    rd(SR, 32'h3, "cnt3_sr");
    rd(CR, 32'h0, "cr_pulse_raz");

    // Clear behaviour
    wr(CR, 32'h2);
    idle(1);
    rd(SR, 32'h0, "clr_sr");
    rd(CR, 32'h2, "cr_clr_rb");
    wr(CR, 32'h0);
    rd(SR, 32'h0, "clr_off_sr");
    wr(CR, 32'h3);
    idle(1);
    rd(SR, 32'h0, "pulse_and_clr_sr");
    wr(CR, 32'h0);

    // Wrap and sticky overflow
    pulses(7);
    idle(1);
    rd(SR, 32'h7, "cnt7_sr");
    chk_eq("ovf_pre_wrap", 32'(overflow), 32'h0);
    pulses(1);
    idle(1);
    rd(SR, OVF_WORD, "wrap_sr");
    chk_eq("ovf_wrap", 32'(overflow), 32'(OVF_EN));
    idle(4);
    rd(SR, OVF_WORD, "sticky_sr");

    // OVF write-0 clear, write-1 no effect
    wr(SR, 32'h0);
    chk_eq("ovf_clr_port", 32'(overflow), 32'h0);
    rd(SR, 32'h0, "ovf_clr_sr");
    pulses(8);
    idle(1);
    chk_eq("ovf_again", 32'(overflow), 32'(OVF_EN));
    wr(SR, 32'h8);
    rd(SR, OVF_WORD, "ovf_w1_sr");

    // Wrap and OVF clear on the same edge: set wins
    wr(SR, 32'h0);
    pulses(7);
    idle(1);
    wr(CR, 32'h1);
    wr(SR, 32'h0);
    chk_eq("set_wins_ovf", 32'(overflow), 32'(OVF_EN));
    rd(SR, OVF_WORD, "set_wins_sr");

    // Unmapped address
    wr(SR, 32'h0);
    rd(BAD, 32'h0, "bad_rd");
    wr(BAD, 32'hDEADBEEF);
    rd(CR, 32'h0, "bad_wr_cr");
    rd(SR, 32'h0, "bad_wr_sr");

    // Simultaneous read and write returns pre-write value
    exp_q.push_back(32'h0);
    tag_q.push_back("rdwr_pre");
    bus(1'b1, 1'b1, CR, 32'h2);
    rd(CR, 32'h2, "rdwr_post");

    // Reset overrides a bus access in the same cycle
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = CR;
    wdata = 32'h3;
    @(posedge clk);
    #1;
    chk_eq("rst_ovr_rdata", rdata, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rd(CR, 32'h0, "rst_ovr_cr");
    rd(SR, 32'h0, "rst_ovr_sr");

    chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
